// File: rtl/xr_pkg.sv
// Shared types for the RAM arbiter slice.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package xr_pkg;

    // Who owns the response slot in the cycle after a grant.
    typedef enum logic [2:0] {
        OWN_NONE  = 3'd0,
        OWN_I_RD  = 3'd1,
        OWN_D_RD  = 3'd2,
        OWN_I_ERR = 3'd3,
        OWN_D_ERR = 3'd4
    } owner_e;

    // Reset value of the round-robin pointer: data port wins first contention.
    localparam logic PRIO_D_RESET = 1'b1;

endpackage

// File: rtl/glb.svh
// Global address map shared by the RAM arbiter and anything that decodes RAM space.
// Purpose: base of the on-chip RAM window; addresses at or above it belong to the RAM.
// Latency/backpressure: not applicable (constants only).
`ifndef GLB_SVH
`define GLB_SVH

`define RAM_BASE_ADDR 14'h1000

`endif

// File: rtl/rr_pick2.sv
// Two-way round-robin pick between instruction and data requesters.
// Latency: grant is combinational; pointer updates on the next rising edge.
// Backpressure: the losing requester simply holds its request until granted.
//
// Ports:
//   clk, rstb          - clock and synchronous active-low reset
//   req_i_i, req_d_i   - instruction / data requests (already reset-gated by caller)
//   gnt_i_o, gnt_d_o   - one-hot (or zero) grants
//   prio_d_o           - current pointer, 1 = data wins the next contention
module rr_pick2
    import xr_pkg::*;
(
    input  logic clk,
    input  logic rstb,
    input  logic req_i_i,
    input  logic req_d_i,
    output logic gnt_i_o,
    output logic gnt_d_o,
    output logic prio_d_o
);

    logic prio_d_q;
    logic prio_d_d;

    always_comb begin
        gnt_d_o  = req_d_i && (!req_i_i || prio_d_q);
        gnt_i_o  = req_i_i && !gnt_d_o;
        prio_d_d = prio_d_q;
        // Only a real contention moves the pointer, and it always swings to the loser.
        if (req_i_i && req_d_i) begin
            prio_d_d = ~prio_d_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            prio_d_q <= PRIO_D_RESET;
        end else begin
            prio_d_q <= prio_d_d;
        end
    end

    assign prio_d_o = prio_d_q;

endmodule

// File: rtl/ram_arb.sv
// Arbitrates an instruction port and a data port onto one single-port RAM.
// Latency: grant and RAM command in the request cycle; read data/error one cycle later.
// Backpressure: requester holds req until gnt; the loser of a contention waits one cycle.
//
// Ports:
//   clk, rstb                          - clock, synchronous active-low reset
//   i_req/i_addr -> i_gnt/i_rvalid/i_err/i_rdata          - instruction (read-only) port
//   d_req/d_we/d_be/d_addr/d_wdata -> d_gnt/d_rvalid/d_err/d_rdata - data port
//   ram_en/ram_we/ram_be/ram_addr/ram_wdata, ram_rdata    - RAM side, read latency 1
`include "glb.svh"

module ram_arb
    import xr_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int ADDR_LEN = 14
) (
    input  logic                  clk,
    input  logic                  rstb,

    input  logic                  i_req,
    input  logic [ADDR_LEN-1:0]   i_addr,
    output logic                  i_gnt,
    output logic                  i_rvalid,
    output logic                  i_err,
    output logic [XLEN-1:0]       i_rdata,

    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [XLEN/8-1:0]     d_be,
    input  logic [ADDR_LEN-1:0]   d_addr,
    input  logic [XLEN-1:0]       d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic                  d_err,
    output logic [XLEN-1:0]       d_rdata,

    output logic                  ram_en,
    output logic                  ram_we,
    output logic [XLEN/8-1:0]     ram_be,
    output logic [ADDR_LEN-3:0]   ram_addr,
    output logic [XLEN-1:0]       ram_wdata,
    input  logic [XLEN-1:0]       ram_rdata
);

    localparam int                BEW  = XLEN / 8;
    localparam logic [ADDR_LEN-1:0] BASE = ADDR_LEN'(`RAM_BASE_ADDR);

    logic                gnt_i;
    logic                gnt_d;
    logic                prio_d;
    logic [ADDR_LEN-1:0] sel_addr;
    logic [ADDR_LEN-1:0] sel_off;
    logic                in_rng;
    logic                unused_off;
    owner_e              owner_q;
    owner_e              owner_d;

    // Requests are masked during reset so no grant or RAM strobe can escape.
    rr_pick2 u_pick (
        .clk      (clk),
        .rstb     (rstb),
        .req_i_i  (i_req && rstb),
        .req_d_i  (d_req && rstb),
        .gnt_i_o  (gnt_i),
        .gnt_d_o  (gnt_d),
        .prio_d_o (prio_d)
    );

    assign i_gnt = gnt_i;
    assign d_gnt = gnt_d;

    // Decode only the granted address; byte-offset bits are dropped.
    assign sel_addr   = gnt_d ? d_addr : i_addr;
    assign in_rng     = (sel_addr >= BASE);
    assign sel_off    = sel_addr - BASE;
    assign unused_off = ^{sel_off[1:0], prio_d};

    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_be    = '0;
        ram_addr  = sel_off[ADDR_LEN-1:2];
        ram_wdata = '0;
        owner_d   = OWN_NONE;
        if (gnt_d) begin
            ram_wdata = d_wdata;
            if (in_rng) begin
                ram_en  = 1'b1;
                ram_we  = d_we;
                ram_be  = d_be;
                owner_d = d_we ? OWN_NONE : OWN_D_RD;
            end else begin
                owner_d = OWN_D_ERR;
            end
        end else if (gnt_i) begin
            if (in_rng) begin
                ram_en  = 1'b1;
                ram_be  = {BEW{1'b1}};
                owner_d = OWN_I_RD;
            end else begin
                owner_d = OWN_I_ERR;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            owner_q <= OWN_NONE;
        end else begin
            owner_q <= owner_d;
        end
    end

    // Responses are gated by rstb so a reset in the response cycle kills them.
    always_comb begin
        i_rvalid = 1'b0;
        i_err    = 1'b0;
        i_rdata  = '0;
        d_rvalid = 1'b0;
        d_err    = 1'b0;
        d_rdata  = '0;
        if (rstb) begin
            case (owner_q)
                OWN_I_RD: begin
                    i_rvalid = 1'b1;
                    i_rdata  = ram_rdata;
                end
                OWN_D_RD: begin
                    d_rvalid = 1'b1;
                    d_rdata  = ram_rdata;
                end
                OWN_I_ERR: begin
                    i_rvalid = 1'b1;
                    i_err    = 1'b1;
                end
                OWN_D_ERR: begin
                    d_rvalid = 1'b1;
                    d_err    = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arb.sv
`ifndef RAM_BASE_ADDR
`include "glb.svh"
`endif

module tb_ram_arb;

    localparam int XLEN     = 32;
    localparam int ADDR_LEN = 14;

    logic                clk = 1'b0;
    logic                rstb;
    logic                i_req;
    logic [ADDR_LEN-1:0] i_addr;
    logic                i_gnt, i_rvalid, i_err;
    logic [XLEN-1:0]     i_rdata;
    logic                d_req, d_we;
    logic [3:0]          d_be;
    logic [ADDR_LEN-1:0] d_addr;
    logic [XLEN-1:0]     d_wdata;
    logic                d_gnt, d_rvalid, d_err;
    logic [XLEN-1:0]     d_rdata;
    logic                ram_en, ram_we;
    logic [3:0]          ram_be;
    logic [ADDR_LEN-3:0] ram_addr;
    logic [XLEN-1:0]     ram_wdata;
    logic [XLEN-1:0]     ram_rdata;

    logic [ADDR_LEN-1:0] base;
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ram_arb #(.XLEN(XLEN), .ADDR_LEN(ADDR_LEN)) dut (
        .clk(clk), .rstb(rstb),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
        .i_err(i_err), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_err(d_err), .d_rdata(d_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_be(ram_be), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    // Advance to just after the next rising edge; inputs change here.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_be = 4'h0;
        i_addr = base; d_addr = base; d_wdata = '0;
    endtask

    task automatic test_reset();
        rstb = 1'b0;
        i_req = 1'b1; d_req = 1'b1; d_we = 1'b1; d_be = 4'hf;
        i_addr = base; d_addr = base;
        ram_rdata = 32'hdead_beef;
        cyc(); cyc(); #1;
        n_tests++; if (i_gnt !== 1'b0) begin n_fail++; $display("FAIL rst_i_gnt got %b exp 0", i_gnt); end
        n_tests++; if (d_gnt !== 1'b0) begin n_fail++; $display("FAIL rst_d_gnt got %b exp 0", d_gnt); end
        n_tests++; if (ram_en !== 1'b0) begin n_fail++; $display("FAIL rst_ram_en got %b exp 0", ram_en); end
        n_tests++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL rst_ram_we got %b exp 0", ram_we); end
        n_tests++; if ({i_rvalid, d_rvalid, i_err, d_err} !== 4'b0) begin n_fail++;
            $display("FAIL rst_rvalid got %b exp 0000", {i_rvalid, d_rvalid, i_err, d_err}); end
        n_tests++; if (i_rdata !== 32'h0 || d_rdata !== 32'h0) begin n_fail++;
            $display("FAIL rst_rdata got %h/%h exp 0", i_rdata, d_rdata); end
        idle();
        cyc();
        rstb = 1'b1;
        cyc();
    endtask

    task automatic test_ifetch();
        i_req = 1'b1; i_addr = base + 14'h10;
        #1;
        n_tests++; if ({i_gnt, d_gnt} !== 2'b10) begin n_fail++; $display("FAIL if_gnt got %b exp 10", {i_gnt, d_gnt}); end
        n_tests++; if (ram_en !== 1'b1 || ram_we !== 1'b0) begin n_fail++;
            $display("FAIL if_en_we got %b%b exp 10", ram_en, ram_we); end
        n_tests++; if (ram_addr !== 12'd4) begin n_fail++; $display("FAIL if_addr got %0d exp 4", ram_addr); end
        n_tests++; if (ram_be !== 4'hf) begin n_fail++; $display("FAIL if_be got %h exp f", ram_be); end
        cyc();
        idle();
        ram_rdata = 32'hcafe_0001;
        #1;
        n_tests++; if (i_rvalid !== 1'b1 || i_err !== 1'b0) begin n_fail++;
            $display("FAIL if_rvalid got %b%b exp 10", i_rvalid, i_err); end
        n_tests++; if (i_rdata !== 32'hcafe_0001) begin n_fail++; $display("FAIL if_rdata got %h exp cafe0001", i_rdata); end
        n_tests++; if (d_rvalid !== 1'b0 || d_rdata !== 32'h0) begin n_fail++;
            $display("FAIL if_d_quiet got %b %h exp 0 0", d_rvalid, d_rdata); end
        cyc(); #1;
        n_tests++; if (i_rvalid !== 1'b0) begin n_fail++; $display("FAIL if_pulse got %b exp 0", i_rvalid); end
    endtask

    // Pointer is 1 after reset and untouched by the uncontended fetch: D,I,D,I.
    task automatic test_contention();
        logic [3:0] exp_d;
        logic       prev_d;
        exp_d = 4'b0101;
        prev_d = 1'b0;
        i_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
        i_addr = base + 14'h20; d_addr = base + 14'h40;
        for (int k = 0; k < 5; k++) begin
            if (k == 4) idle();
            ram_rdata = 32'h0000_1000 + k;
            #1;
            if (k < 4) begin
                n_tests++; if ({d_gnt, i_gnt} !== {exp_d[k], ~exp_d[k]}) begin n_fail++;
                    $display("FAIL cont_gnt[%0d] got d%b i%b exp d%b", k, d_gnt, i_gnt, exp_d[k]); end
            end
            if (k > 0) begin
                n_tests++; if ({d_rvalid, i_rvalid} !== {prev_d, ~prev_d}) begin n_fail++;
                    $display("FAIL cont_rv[%0d] got d%b i%b exp d%b", k, d_rvalid, i_rvalid, prev_d); end
                n_tests++; if ((prev_d ? d_rdata : i_rdata) !== 32'h0000_1000 + k) begin n_fail++;
                    $display("FAIL cont_rdata[%0d] got %h exp %h", k, prev_d ? d_rdata : i_rdata, 32'h1000 + k); end
            end
            if (k < 4) prev_d = exp_d[k];
            cyc();
        end
    endtask

    task automatic test_write();
        d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = base + 14'h8; d_wdata = 32'h1234_5678;
        #1;
        n_tests++; if (d_gnt !== 1'b1) begin n_fail++; $display("FAIL wr_gnt got %b exp 1", d_gnt); end
        n_tests++; if ({ram_en, ram_we} !== 2'b11) begin n_fail++; $display("FAIL wr_en_we got %b exp 11", {ram_en, ram_we}); end
        n_tests++; if (ram_be !== 4'b0011) begin n_fail++; $display("FAIL wr_be got %b exp 0011", ram_be); end
        n_tests++; if (ram_addr !== 12'd2) begin n_fail++; $display("FAIL wr_addr got %0d exp 2", ram_addr); end
        n_tests++; if (ram_wdata !== 32'h1234_5678) begin n_fail++; $display("FAIL wr_wdata got %h exp 12345678", ram_wdata); end
        cyc();
        idle();
        #1;
        n_tests++; if ({d_rvalid, d_err, i_rvalid} !== 3'b000) begin n_fail++;
            $display("FAIL wr_no_rvalid got %b exp 000", {d_rvalid, d_err, i_rvalid}); end
    endtask

    task automatic test_oor();
        cyc();
        d_req = 1'b1; d_we = 1'b0; d_addr = base - 14'h4;
        #1;
        n_tests++; if ({d_gnt, ram_en} !== 2'b10) begin n_fail++; $display("FAIL oor_gnt_en got %b exp 10", {d_gnt, ram_en}); end
        cyc();
        idle();
        ram_rdata = 32'ha5a5_a5a5;
        #1;
        n_tests++; if ({d_rvalid, d_err} !== 2'b11) begin n_fail++; $display("FAIL oor_err got %b exp 11", {d_rvalid, d_err}); end
        n_tests++; if (d_rdata !== 32'h0) begin n_fail++; $display("FAIL oor_rdata got %h exp 0", d_rdata); end
        cyc();
    endtask

    task automatic test_reset_pending();
        // One contention moves the pointer to 0 so the reset value is observable.
        i_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
        #1;
        n_tests++; if (d_gnt !== 1'b1) begin n_fail++; $display("FAIL rp_pre got %b exp 1", d_gnt); end
        cyc();
        d_req = 1'b0;
        #1;
        n_tests++; if (i_gnt !== 1'b1) begin n_fail++; $display("FAIL rp_igrant got %b exp 1", i_gnt); end
        cyc();
        idle();
        rstb = 1'b0;
        ram_rdata = 32'h7777_7777;
        #1;
        n_tests++; if ({i_rvalid, i_err, d_rvalid} !== 3'b000 || i_rdata !== 32'h0) begin n_fail++;
            $display("FAIL rp_suppress got %b %h exp 000 0", {i_rvalid, i_err, d_rvalid}, i_rdata); end
        cyc();
        rstb = 1'b1;
        #1;
        n_tests++; if ({i_rvalid, d_rvalid} !== 2'b00) begin n_fail++;
            $display("FAIL rp_owner_none got %b exp 00", {i_rvalid, d_rvalid}); end
        cyc();
        i_req = 1'b1; d_req = 1'b1;
        #1;
        n_tests++; if ({d_gnt, i_gnt} !== 2'b10) begin n_fail++;
            $display("FAIL rp_first_cont got d%b i%b exp d1 i0", d_gnt, i_gnt); end
        cyc();
        idle();
        cyc();
    endtask

    // Pointer is 0 here; uncontended traffic must not move it.
    task automatic test_uncontended();
        for (int k = 0; k < 4; k++) begin
            i_req = (k % 2 == 0); d_req = (k % 2 == 1);
            #1;
            n_tests++; if ({i_gnt, d_gnt} !== {i_req, d_req}) begin n_fail++;
                $display("FAIL unc_gnt[%0d] got i%b d%b exp i%b d%b", k, i_gnt, d_gnt, i_req, d_req); end
            cyc();
        end
        i_req = 1'b1; d_req = 1'b1;
        #1;
        n_tests++; if ({i_gnt, d_gnt} !== 2'b10) begin n_fail++;
            $display("FAIL unc_cont1 got i%b d%b exp i1 d0", i_gnt, d_gnt); end
        cyc(); #1;
        n_tests++; if ({i_gnt, d_gnt} !== 2'b01) begin n_fail++;
            $display("FAIL unc_cont2 got i%b d%b exp i0 d1", i_gnt, d_gnt); end
        cyc();
        idle();
        cyc();
    endtask

    initial begin
        base = `RAM_BASE_ADDR;
        d_wdata = '0;
        test_reset();
        test_ifetch();
        test_contention();
        test_write();
        test_oor();
        test_reset_pending();
        test_uncontended();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
